four_bank_mem_responder: RTL and testbench

- Memory-side responder for the cache-to-memory interface driven by the cache controller: accepts word reads/writes on addr/data_in/rd/wr.
- Returns read data with fixed latency and reports bank conflicts on stall.
- Four interleaved banks, each occupied 4 cycles per accepted access; independent banks overlap, so a 4-word line fill/writeback streams one request per cycle.

---
 rtl/four_bank_mem_responder.sv | 145 ++++++++++++++
 tb/tb_four_bank_mem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_bank_mem_responder.sv
//============================================================================
// Module   : four_bank_mem_responder
// Purpose  : Word-addressed memory responder with four interleaved banks,
//            fixed read latency, per-bank stall and sticky illegal-request flag.
//            Optional stall counter output when BANK_STALL_CNT_EN is defined.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module four_bank_mem_responder #(
    parameter int MEM_WORDS = 4096,
    parameter int RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr_i,
    input  logic [15:0] data_in_i,
    input  logic        rd_i,
    input  logic        wr_i,
    input  logic        createdump_i,
    output logic [15:0] data_out_o,
    output logic        rd_valid_o,
    output logic        stall_o,
    output logic [3:0]  busy_o,
    output logic        err_o
`ifdef BANK_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt_o
`endif
);

    localparam int c_ADDR_W = $clog2(MEM_WORDS);

    logic [15:0]         r_mem_q [MEM_WORDS];
    logic [1:0]          r_cnt_q [4];
    logic [1:0]          w_cnt_d [4];
    logic [RD_LAT-1:0]   r_vld_q;
    logic [15:0]         r_data_q [RD_LAT];
    logic                r_err_q;
    logic                w_err_d;

    logic [14:0]         w_word;
    logic [c_ADDR_W-1:0] w_idx;
    logic [1:0]          w_bank;
    logic [3:0]          w_busy;
    logic                w_legal;
    logic                w_illegal;
    logic                w_stall;
    logic                w_accept;
    logic                w_rd_acc;
    logic                w_wr_acc;
    logic                w_unused;

    assign w_word    = addr_i[15:1];
    assign w_idx     = w_word[c_ADDR_W-1:0];
    assign w_bank    = addr_i[2:1];
    assign w_legal   = (rd_i ^ wr_i) & ~addr_i[0];
    assign w_illegal = (rd_i | wr_i) & ~w_legal;
    assign w_stall   = w_legal & w_busy[w_bank];
    // A request presented while reset is high must never reach the array.
    assign w_accept  = w_legal & ~w_busy[w_bank] & ~rst;
    assign w_rd_acc  = w_accept & rd_i;
    assign w_wr_acc  = w_accept & wr_i;
    assign w_unused  = ^{createdump_i, w_word};

    generate
        for (genvar g = 0; g < 4; g++) begin : g_busy
            assign w_busy[g] = |r_cnt_q[g];
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_cnt_d[i] = (r_cnt_q[i] != 2'd0) ? (r_cnt_q[i] - 2'd1) : 2'd0;
            if (w_accept && (w_bank == 2'(i))) begin
                w_cnt_d[i] = 2'd3;
            end
        end
    end

    assign w_err_d = r_err_q | w_illegal;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem_q[w_idx] <= data_in_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt_q[i] <= 2'd0;
            end
            r_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                r_data_q[k] <= 16'h0000;
            end
            r_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_cnt_q[i] <= w_cnt_d[i];
            end
            r_vld_q[0] <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_q[0] <= r_mem_q[w_idx];
            end
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld_q[k]  <= r_vld_q[k-1];
                r_data_q[k] <= r_data_q[k-1];
            end
            r_err_q <= w_err_d;
        end
    end

    assign busy_o     = w_busy;
    assign stall_o    = w_stall;
    assign err_o      = r_err_q;
    assign rd_valid_o = r_vld_q[RD_LAT-1];
    assign data_out_o = r_vld_q[RD_LAT-1] ? r_data_q[RD_LAT-1] : 16'h0000;

`ifdef BANK_STALL_CNT_EN
    logic [15:0] r_stall_cnt_q;
    logic [15:0] w_stall_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_stall && (r_stall_cnt_q != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt_q <= 16'h0000;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall_cnt_o = r_stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_four_bank_mem_responder.sv
//============================================================================
// Module   : tb_four_bank_mem_responder
// Purpose  : Directed self-checking bench for four_bank_mem_responder.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_four_bank_mem_responder;

    localparam int MEM_WORDS = 4096;
    localparam int RD_LAT    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic        createdump;
    logic [15:0] data_out;
    logic        rd_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;
`ifdef BANK_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;

    four_bank_mem_responder #(
        .MEM_WORDS (MEM_WORDS),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_i       (addr),
        .data_in_i    (data_in),
        .rd_i         (rd),
        .wr_i         (wr),
        .createdump_i (createdump),
        .data_out_o   (data_out),
        .rd_valid_o   (rd_valid),
        .stall_o      (stall),
        .busy_o       (busy),
        .err_o        (err)
`ifdef BANK_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge; outputs are sampled 4 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; rd = 1'b1; wr = 1'b0; addr = 16'h0100; data_in = 16'h0000;
        repeat (2) tick();
        #4;
        n_total++;
        if ({data_out, rd_valid, stall, busy, err} !== 23'd0)
            $display("FAIL reset_outputs: got %h want 0", {data_out, rd_valid, stall, busy, err});
        else n_pass++;
        tick();
        rst = 1'b0; rd = 1'b0;
        #4;
        n_total++;
        if ({busy, rd_valid} !== 5'b0)
            $display("FAIL reset_no_accept: busy=%b rd_valid=%b want 0000/0", busy, rd_valid);
        else n_pass++;
        tick();
        tick();
        #4;
        n_total++;
        if (rd_valid !== 1'b0)
            $display("FAIL reset_no_return: rd_valid=%b want 0", rd_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_write_read();
        wr = 1'b1; addr = 16'h0100; data_in = 16'hBEEF;
        #4;
        n_total++;
        if (stall !== 1'b0) $display("FAIL wr_stall: got %b want 0", stall); else n_pass++;
        tick();
        wr = 1'b0;
        #4;
        n_total++;
        if (busy !== 4'b0001) $display("FAIL wr_busy: got %b want 0001", busy); else n_pass++;
        tick(); tick(); tick();
        rd = 1'b1; addr = 16'h0100;
        #4;
        n_total++;
        if (stall !== 1'b0) $display("FAIL rd_stall: got %b want 0", stall); else n_pass++;
        tick();
        rd = 1'b0;
        #4;
        n_total++;
        if (rd_valid !== 1'b0) $display("FAIL rd_early: rd_valid=%b want 0", rd_valid); else n_pass++;
        tick();
        #4;
        n_total++;
        if ({rd_valid, data_out} !== {1'b1, 16'hBEEF})
            $display("FAIL rd_data: got %b/%h want 1/beef", rd_valid, data_out);
        else n_pass++;
        tick();
        #4;
        n_total++;
        if ({rd_valid, data_out} !== 17'd0)
            $display("FAIL rd_hold: got %b/%h want 0/0000", rd_valid, data_out);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_stream();
        logic [15:0] vals [4];
        logic [3:0]  busy_exp [8];
        vals     = '{16'hA000, 16'hA111, 16'hA222, 16'hA333};
        busy_exp = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            wr = 1'b1; addr = 16'h0200 + 16'(2 * k); data_in = vals[k];
            #4;
            n_total++;
            if (stall !== 1'b0) $display("FAIL stream_wr_stall%0d: got %b want 0", k, stall); else n_pass++;
            tick();
        end
        idle(4);
        for (int c = 0; c < 8; c++) begin
            logic        v_exp;
            logic [15:0] d_exp;
            rd   = (c < 4);
            addr = 16'h0200 + 16'(2 * (c % 4));
            v_exp = (c >= 2) && (c <= 5);
            d_exp = v_exp ? vals[c-2] : 16'h0000;
            #4;
            n_total++;
            if (stall !== 1'b0) $display("FAIL stream_stall c%0d: got %b want 0", c, stall); else n_pass++;
            n_total++;
            if (busy !== busy_exp[c])
                $display("FAIL stream_busy c%0d: got %b want %b", c, busy, busy_exp[c]);
            else n_pass++;
            n_total++;
            if ({rd_valid, data_out} !== {v_exp, d_exp})
                $display("FAIL stream_data c%0d: got %b/%h want %b/%h", c, rd_valid, data_out, v_exp, d_exp);
            else n_pass++;
            tick();
        end
        idle(2);
    endtask

    task automatic test_conflict();
        wr = 1'b1; addr = 16'h0208; data_in = 16'h5A5A;
        tick();
        idle(4);
        for (int c = 0; c < 8; c++) begin
            logic        s_exp;
            logic        v_exp;
            logic [15:0] d_exp;
            rd    = (c <= 4);
            addr  = (c == 0) ? 16'h0200 : 16'h0208;
            s_exp = (c >= 1) && (c <= 3);
            v_exp = (c == 2) || (c == 6);
            d_exp = (c == 2) ? 16'hA000 : ((c == 6) ? 16'h5A5A : 16'h0000);
            #4;
            n_total++;
            if (stall !== s_exp) $display("FAIL conflict_stall c%0d: got %b want %b", c, stall, s_exp); else n_pass++;
            n_total++;
            if ({rd_valid, data_out} !== {v_exp, d_exp})
                $display("FAIL conflict_data c%0d: got %b/%h want %b/%h", c, rd_valid, data_out, v_exp, d_exp);
            else n_pass++;
            tick();
        end
`ifdef BANK_STALL_CNT_EN
        n_total++;
        if (stall_cnt !== 16'd3) $display("FAIL stall_cnt: got %0d want 3", stall_cnt); else n_pass++;
`endif
        idle(3);
    endtask

    task automatic test_illegal();
        rd = 1'b1; wr = 1'b1; addr = 16'h0100; data_in = 16'hDEAD;
        #4;
        n_total++;
        if ({stall, err} !== 2'b00) $display("FAIL ill_both_now: stall/err=%b want 00", {stall, err}); else n_pass++;
        tick();
        rd = 1'b0; wr = 1'b0;
        #4;
        n_total++;
        if ({err, busy} !== 5'b1_0000) $display("FAIL ill_both_next: err/busy=%b want 1/0000", {err, busy}); else n_pass++;
        idle(2);
        rd = 1'b1; addr = 16'h0100;
        tick();
        rd = 1'b0;
        tick();
        #4;
        n_total++;
        if ({rd_valid, data_out, err} !== {1'b1, 16'hBEEF, 1'b1})
            $display("FAIL ill_no_write: got %b/%h err=%b want 1/beef err=1", rd_valid, data_out, err);
        else n_pass++;
        tick();
        rst = 1'b1;
        #4;
        n_total++;
        if (err !== 1'b0) $display("FAIL ill_reset_clear: err=%b want 0", err); else n_pass++;
        tick();
        rst = 1'b0; rd = 1'b1; addr = 16'h0011;
        #4;
        n_total++;
        if ({stall, err} !== 2'b00) $display("FAIL ill_odd_now: stall/err=%b want 00", {stall, err}); else n_pass++;
        tick();
        rd = 1'b0;
        #4;
        n_total++;
        if ({err, busy} !== 5'b1_0000) $display("FAIL ill_odd_next: err/busy=%b want 1/0000", {err, busy}); else n_pass++;
        idle(3);
        #4;
        n_total++;
        if (err !== 1'b1) $display("FAIL ill_sticky: err=%b want 1", err); else n_pass++;
        tick();
    endtask

    task automatic test_reset_inflight();
        rd = 1'b1; addr = 16'h0100;
        tick();
        rd = 1'b0; rst = 1'b1;
        #4;
        n_total++;
        if ({busy, rd_valid, err} !== 6'd0)
            $display("FAIL inflight_rst: busy=%b rd_valid=%b err=%b want 0000/0/0", busy, rd_valid, err);
        else n_pass++;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #4;
            n_total++;
            if (rd_valid !== 1'b0) $display("FAIL inflight_drop c%0d: rd_valid=%b want 0", c, rd_valid); else n_pass++;
            tick();
        end
        rd = 1'b1; addr = 16'h0100;
        tick();
        rd = 1'b0;
        tick();
        #4;
        n_total++;
        if ({rd_valid, data_out} !== {1'b1, 16'hBEEF})
            $display("FAIL inflight_mem_kept: got %b/%h want 1/beef", rd_valid, data_out);
        else n_pass++;
        idle(4);
    endtask

    task automatic test_wrap();
        wr = 1'b1; addr = 16'h0000; data_in = 16'h1234;
        tick();
        idle(4);
        rd = 1'b1; addr = 16'(2 * MEM_WORDS);
        #4;
        n_total++;
        if (stall !== 1'b0) $display("FAIL wrap_stall: got %b want 0", stall); else n_pass++;
        tick();
        rd = 1'b0;
        tick();
        #4;
        n_total++;
        if ({rd_valid, data_out} !== {1'b1, 16'h1234})
            $display("FAIL wrap_data: got %b/%h want 1/1234", rd_valid, data_out);
        else n_pass++;
        idle(2);
    endtask

    initial begin
        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000; createdump = 1'b0;
        test_reset();
        test_write_read();
        test_stream();
        test_conflict();
        test_illegal();
        test_reset_inflight();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
